matmul_job_scheduler: RTL and testbench
=======================================

# matmul_job_scheduler

Job-queue controller that sits in front of the 4x4 systolic matmul-with-BRAM top level and sequences it through back-to-back multiplications. A host pushes job descriptors (A/B/C base addresses and strides) into a small FIFO. The scheduler pops one job at a time and drives the matmul control inputs: PE clear, start, wait for done, then clear-done. It counts completed jobs and raises a sticky interrupt.

## Interface
- `DEPTH`, default 4: descriptor FIFO entries; power of two, at least 2.
- `AWIDTH`, default 10: BRAM address width.
- `STRIDE_WIDTH`, default 8: address stride width.
- `TIMEOUT_CYCLES`, default 1024: watchdog limit, used only when the macro is enabled.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `job_valid` in 1: host descriptor valid.
- `job_ready` out 1: FIFO can accept; equals `count < DEPTH`.
- `job_addr_a`, `job_addr_b`, `job_addr_c` in AWIDTH each: base addresses.
- `job_stride_a`, `job_stride_b`, `job_stride_c` in STRIDE_WIDTH each: strides.
- `mm_address_mat_a`, `mm_address_mat_b`, `mm_address_mat_c` out AWIDTH each: registered to the matmul.
- `mm_address_stride_a`, `mm_address_stride_b`, `mm_address_stride_c` out STRIDE_WIDTH each: registered to the matmul.
- `mm_pe_resetn` out 1: active-low PE accumulator clear.
- `mm_start_reg` out 1: start request to the matmul.
- `mm_clear_done_reg` out 1: done acknowledge to the matmul.
- `mm_done` in 1: matmul done level; held until cleared.
- `busy` out 1: high in any state other than IDLE.
- `fifo_count` out clog2(DEPTH)+1: number of queued descriptors.
- `jobs_done` out 8: completed-job counter.
- `irq` out 1: sticky completion interrupt.
- `irq_clear` in 1: clears `irq` and `err_timeout`.
- `err_timeout` out 1: sticky watchdog error.

## Operation
- Push: a descriptor is written when `job_valid && job_ready`.
  - There is no write-through bypass: a push into an empty FIFO is poppable on the next cycle.
  - Push and pop in the same cycle are allowed; `count` is unchanged.
  - When the FIFO is full, `job_ready` is 0, so no push can coincide with full.
- FSM states: IDLE, PE_CLR, START, WAIT, CLEAR.
  - IDLE: if `count != 0`, pop the head and latch all six `mm_*` address/stride registers, then go to PE_CLR. Otherwise stay in IDLE.
  - PE_CLR: `mm_pe_resetn` = 0 for exactly one cycle, then go to START.
  - START: `mm_start_reg` = 1 for exactly one cycle, then go to WAIT.
  - WAIT: on `mm_done` = 1, go to CLEAR and increment `jobs_done`. `jobs_done` wraps 255 to 0.
  - CLEAR: `mm_clear_done_reg` = 1 for one cycle, set `irq`, then go to IDLE.
- The `mm_*` address/stride registers hold their values from the pop until the next pop.
- `irq_clear` and a set of `irq` in the same cycle: set wins. The same rule applies to `err_timeout`.
- Reset mid-job: every register returns to its reset value, the FIFO is emptied, and the in-flight job is dropped. Recovering the matmul itself is the system's responsibility.
- Reset values:
  - `mm_pe_resetn` = 1.
  - `job_ready` = 1.
  - All other outputs = 0.

## Timing
- All outputs are registered except `job_ready`, which is decoded from the registered count.
- Push into an empty idle scheduler at edge 0 (T0) gives the following sequence:
  - Pop at edge 1.
  - `mm_pe_resetn` = 0 in cycle 2.
  - `mm_start_reg` = 1 in cycle 3.
  - WAIT from cycle 4.
- `mm_done` sampled high at edge N gives `mm_clear_done_reg` = 1 in cycle N+1. In the same cycle `irq` = 1 and `jobs_done` is updated.
- Back-to-back jobs: IDLE lasts one cycle. Done-acknowledge to the next PE clear is 2 cycles.
- `busy` goes high on the cycle after the pop edge and low on return to IDLE.

## Configuration
- `MATMUL_SCHED_TIMEOUT_EN` defined:
  - A WAIT-cycle counter is built; it resets on entering WAIT.
  - If it reaches `TIMEOUT_CYCLES` without `mm_done`, the FSM goes to CLEAR, sets `err_timeout` and `irq`, and does not increment `jobs_done`.
- `MATMUL_SCHED_TIMEOUT_EN` undefined:
  - No counter is built; WAIT waits indefinitely.
  - `err_timeout` is tied to 0.

## Test plan
- Single job: push A=0x000, B=0x100, C=0x200, strides 1/1/1; bench asserts `mm_done` 20 cycles after start. Required response:
  - Pulses land on the exact cycles listed under Timing.
  - `mm_address_*` = 0x000/0x100/0x200.
  - `jobs_done` = 1 and `irq` = 1.
- Fill: push 5 jobs with DEPTH=4 while the first is in WAIT. Required response:
  - `job_ready` drops after the FIFO holds 4.
  - All jobs execute in order.
  - `jobs_done` = 5.
- Wrap: run 257 jobs; `jobs_done` reads 1 at the end.
- `irq_clear` asserted in the same cycle as CLEAR: `irq` remains 1; a later standalone `irq_clear` gives `irq` = 0.
- Reset mid-WAIT with 2 jobs queued. Required response:
  - All outputs take their reset values.
  - `fifo_count` = 0.
  - No pulses follow after reset is released.
- With `MATMUL_SCHED_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, `mm_done` held at 0. Required response:
  - CLEAR occurs 16 cycles into WAIT.
  - `err_timeout` = 1 and `irq` = 1.
  - `jobs_done` is unchanged.

Source files
------------

// File: rtl/matmul_job_scheduler.sv
// matmul_job_scheduler: queues matmul job descriptors and runs the 4x4 systolic
//   matmul through PE clear -> start -> wait done -> clear done, one job at a time.
// Ports: clk/resetn; host push job_valid/job_ready + job_addr_*/job_stride_*;
//   matmul side mm_address_*/mm_address_stride_*, mm_pe_resetn, mm_start_reg,
//   mm_clear_done_reg, mm_done; status busy, fifo_count, jobs_done, irq, err_timeout,
//   irq_clear.
// Option: define MATMUL_SCHED_TIMEOUT_EN to build the WAIT watchdog (TIMEOUT_CYCLES).

// Generic descriptor FIFO: W-bit entries, DEPTH deep (power of two).
// Latency: a pushed entry is visible at the head on the next cycle (no bypass).
// Backpressure: push_rdy = count < DEPTH; pop must only be asserted when count != 0.
module matmul_sched_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push_vld,
  input  logic [W-1:0]  push_dat,
  output logic          push_rdy,
  input  logic          pop,
  output logic [W-1:0]  pop_dat,
  output logic [CW-1:0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push;

  assign push_rdy = (count_q < CW'(DEPTH));
  assign push     = push_vld && push_rdy;
  assign pop_dat  = mem_q[rd_ptr_q];
  assign count    = count_q;

  // Storage carries no reset: entries are only read once count says they are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_dat;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// Job scheduler top: pops descriptors and sequences the matmul control handshake.
// Latency: push at edge 0 -> pop edge 1 -> PE clear cycle 2 -> start cycle 3 -> WAIT.
// Backpressure: job_ready drops while the FIFO is full; jobs advance only on mm_done.
module matmul_job_scheduler #(
  parameter int DEPTH          = 4,
  parameter int AWIDTH         = 10,
  parameter int STRIDE_WIDTH   = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      job_valid,
  output logic                      job_ready,
  input  logic [AWIDTH-1:0]         job_addr_a,
  input  logic [AWIDTH-1:0]         job_addr_b,
  input  logic [AWIDTH-1:0]         job_addr_c,
  input  logic [STRIDE_WIDTH-1:0]   job_stride_a,
  input  logic [STRIDE_WIDTH-1:0]   job_stride_b,
  input  logic [STRIDE_WIDTH-1:0]   job_stride_c,
  output logic [AWIDTH-1:0]         mm_address_mat_a,
  output logic [AWIDTH-1:0]         mm_address_mat_b,
  output logic [AWIDTH-1:0]         mm_address_mat_c,
  output logic [STRIDE_WIDTH-1:0]   mm_address_stride_a,
  output logic [STRIDE_WIDTH-1:0]   mm_address_stride_b,
  output logic [STRIDE_WIDTH-1:0]   mm_address_stride_c,
  output logic                      mm_pe_resetn,
  output logic                      mm_start_reg,
  output logic                      mm_clear_done_reg,
  input  logic                      mm_done,
  output logic                      busy,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic [7:0]                jobs_done,
  output logic                      irq,
  input  logic                      irq_clear,
  output logic                      err_timeout
);
  typedef struct packed {
    logic [AWIDTH-1:0]       addr_a;
    logic [AWIDTH-1:0]       addr_b;
    logic [AWIDTH-1:0]       addr_c;
    logic [STRIDE_WIDTH-1:0] stride_a;
    logic [STRIDE_WIDTH-1:0] stride_b;
    logic [STRIDE_WIDTH-1:0] stride_c;
  } job_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_PE_CLR, ST_START, ST_WAIT, ST_CLEAR
  } state_e;

  state_e state_q, state_d;
  job_t   push_job, head_job, job_q;
  logic   pop;
  logic   timeout_hit;
  logic   pe_resetn_q, pe_resetn_d;
  logic   start_q, start_d;
  logic   clear_done_q, clear_done_d;
  logic   busy_q, busy_d;
  logic   irq_q;
  logic   irq_set;
  logic [7:0] jobs_done_q;

  assign push_job = {job_addr_a, job_addr_b, job_addr_c,
                     job_stride_a, job_stride_b, job_stride_c};

  matmul_sched_fifo #(
    .W     ($bits(job_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push_vld (job_valid),
    .push_dat (push_job),
    .push_rdy (job_ready),
    .pop      (pop),
    .pop_dat  (head_job),
    .count    (fifo_count)
  );

  assign pop = (state_q == ST_IDLE) && (fifo_count != '0);

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (fifo_count != '0) state_d = ST_PE_CLR;
      ST_PE_CLR: state_d = ST_START;
      ST_START:  state_d = ST_WAIT;
      ST_WAIT:   if (mm_done || timeout_hit) state_d = ST_CLEAR;
      ST_CLEAR:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output decode from the next state so every control output is a flop that
  // lines up with the state it belongs to.
  always_comb begin
    pe_resetn_d  = (state_d != ST_PE_CLR);
    start_d      = (state_d == ST_START);
    clear_done_d = (state_d == ST_CLEAR);
    busy_d       = (state_d != ST_IDLE);
  end

  // irq is set on entry to CLEAR and held set through the CLEAR cycle, so an
  // irq_clear landing on either of those edges loses to the set.
  assign irq_set = clear_done_d || clear_done_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pe_resetn_q  <= 1'b1;
      start_q      <= 1'b0;
      clear_done_q <= 1'b0;
      busy_q       <= 1'b0;
      jobs_done_q  <= '0;
      irq_q        <= 1'b0;
      job_q        <= '0;
    end else begin
      pe_resetn_q  <= pe_resetn_d;
      start_q      <= start_d;
      clear_done_q <= clear_done_d;
      busy_q       <= busy_d;
      if (pop) job_q <= head_job;
      // A completed job counts only via mm_done, never via the watchdog.
      if (state_q == ST_WAIT && mm_done) jobs_done_q <= jobs_done_q + 8'd1;
      if (irq_set)        irq_q <= 1'b1;
      else if (irq_clear) irq_q <= 1'b0;
    end
  end

`ifdef MATMUL_SCHED_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TCW-1:0] wait_cnt_q;
  logic           to_job_q;
  logic           err_q;

  // Counter sits at zero outside WAIT, so it restarts on every WAIT entry.
  assign timeout_hit = (state_q == ST_WAIT) && !mm_done &&
                       (wait_cnt_q == TCW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wait_cnt_q <= '0;
      to_job_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (state_q == ST_WAIT) wait_cnt_q <= wait_cnt_q + TCW'(1);
      else                    wait_cnt_q <= '0;
      if (timeout_hit)                to_job_q <= 1'b1;
      else if (state_q == ST_CLEAR)   to_job_q <= 1'b0;
      // Same set-wins window as irq: the timeout edge plus the CLEAR cycle.
      if (timeout_hit || (state_q == ST_CLEAR && to_job_q)) err_q <= 1'b1;
      else if (irq_clear)                                   err_q <= 1'b0;
    end
  end

  assign err_timeout = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
  assign err_timeout        = 1'b0;
`endif

  assign mm_address_mat_a    = job_q.addr_a;
  assign mm_address_mat_b    = job_q.addr_b;
  assign mm_address_mat_c    = job_q.addr_c;
  assign mm_address_stride_a = job_q.stride_a;
  assign mm_address_stride_b = job_q.stride_b;
  assign mm_address_stride_c = job_q.stride_c;
  assign mm_pe_resetn        = pe_resetn_q;
  assign mm_start_reg        = start_q;
  assign mm_clear_done_reg   = clear_done_q;
  assign busy                = busy_q;
  assign jobs_done           = jobs_done_q;
  assign irq                 = irq_q;
endmodule

// File: tb/tb_matmul_job_scheduler.sv
// Testbench for matmul_job_scheduler: scoreboard of pushed descriptors compared
// against the mm_* registers at each PE clear, plus cycle-exact handshake timing.
// A small behavioural matmul raises mm_done a set number of cycles after start.
module tb_matmul_job_scheduler;
  localparam int AW    = 10;
  localparam int SW    = 8;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;
  localparam int JW    = 3 * AW + 3 * SW;

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic          job_valid = 1'b0;
  logic          irq_clear = 1'b0;
  logic          mm_done = 1'b0;
  logic [AW-1:0] job_addr_a = '0, job_addr_b = '0, job_addr_c = '0;
  logic [SW-1:0] job_stride_a = '0, job_stride_b = '0, job_stride_c = '0;
  logic          job_ready, mm_pe_resetn, mm_start_reg, mm_clear_done_reg;
  logic          busy, irq, err_timeout;
  logic [AW-1:0] mm_address_mat_a, mm_address_mat_b, mm_address_mat_c;
  logic [SW-1:0] mm_address_stride_a, mm_address_stride_b, mm_address_stride_c;
  logic [2:0]    fifo_count;
  logic [7:0]    jobs_done;

  logic [JW-1:0] exp_q[$];
  logic [JW-1:0] exp_job;
  wire  [JW-1:0] mm_vec = {mm_address_mat_a, mm_address_mat_b, mm_address_mat_c,
                           mm_address_stride_a, mm_address_stride_b, mm_address_stride_c};
  wire  [6:0]    ctl_vec = {job_ready, mm_pe_resetn, mm_start_reg, mm_clear_done_reg,
                            busy, irq, err_timeout};

  int n_checks = 0;
  int n_pass   = 0;
  int done_delay = 20;
  bit done_en    = 1'b1;
  int done_cnt   = 0;

  always #5 clk = ~clk;

  matmul_job_scheduler #(
    .DEPTH(DEPTH), .AWIDTH(AW), .STRIDE_WIDTH(SW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .resetn(resetn),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_addr_a(job_addr_a), .job_addr_b(job_addr_b), .job_addr_c(job_addr_c),
    .job_stride_a(job_stride_a), .job_stride_b(job_stride_b), .job_stride_c(job_stride_c),
    .mm_address_mat_a(mm_address_mat_a), .mm_address_mat_b(mm_address_mat_b),
    .mm_address_mat_c(mm_address_mat_c),
    .mm_address_stride_a(mm_address_stride_a), .mm_address_stride_b(mm_address_stride_b),
    .mm_address_stride_c(mm_address_stride_c),
    .mm_pe_resetn(mm_pe_resetn), .mm_start_reg(mm_start_reg),
    .mm_clear_done_reg(mm_clear_done_reg), .mm_done(mm_done),
    .busy(busy), .fifo_count(fifo_count), .jobs_done(jobs_done),
    .irq(irq), .irq_clear(irq_clear), .err_timeout(err_timeout)
  );

  // Behavioural matmul: done rises done_delay cycles after start, held until cleared.
  initial begin : mm_model
    forever begin
      @(negedge clk);
      if (!resetn) begin
        mm_done  = 1'b0;
        done_cnt = 0;
      end else begin
        if (mm_clear_done_reg) mm_done = 1'b0;
        if (done_cnt == 1) begin
          mm_done  = 1'b1;
          done_cnt = 0;
        end else if (done_cnt > 1) begin
          done_cnt--;
        end
        if (mm_start_reg && done_en) done_cnt = done_delay;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1);
  end

  task automatic push_job(input logic [AW-1:0] a, input logic [AW-1:0] b,
                          input logic [AW-1:0] c, input logic [SW-1:0] sa,
                          input logic [SW-1:0] sb, input logic [SW-1:0] sc);
    int n = 0;
    @(negedge clk);
    while (!job_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    job_valid = 1'b1;
    job_addr_a = a; job_addr_b = b; job_addr_c = c;
    job_stride_a = sa; job_stride_b = sb; job_stride_c = sc;
    exp_q.push_back({a, b, c, sa, sb, sc});
    @(posedge clk);
    #1 job_valid = 1'b0;
  endtask

  task automatic wait_pe_clr(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!mm_pe_resetn) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_clear(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (mm_clear_done_reg) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    job_valid = 1'b0; irq_clear = 1'b0;
    #2 resetn = 1'b0;
    exp_q.delete();
    @(negedge clk);
    n_checks++; if (ctl_vec !== 7'b1100000) $display("FAIL reset_ctl got=%b want=%b", ctl_vec, 7'b1100000); else n_pass++;
    n_checks++; if (fifo_count !== 3'd0) $display("FAIL reset_count got=%0d want=0", fifo_count); else n_pass++;
    n_checks++; if (jobs_done !== 8'd0) $display("FAIL reset_jobs got=%0d want=0", jobs_done); else n_pass++;
    n_checks++; if (mm_vec !== '0) $display("FAIL reset_addr got=%h want=0", mm_vec); else n_pass++;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_single();
    bit ok;
    int n;
    done_delay = 20;
    push_job(10'h000, 10'h100, 10'h200, 8'd1, 8'd1, 8'd1);
    @(negedge clk);
    n_checks++; if ({fifo_count, busy, mm_pe_resetn} !== {3'd1, 1'b0, 1'b1}) $display("FAIL single_queued got=%b want=%b", {fifo_count, busy, mm_pe_resetn}, {3'd1, 1'b0, 1'b1}); else n_pass++;
    @(negedge clk);
    n_checks++; if ({mm_pe_resetn, busy, fifo_count} !== {1'b0, 1'b1, 3'd0}) $display("FAIL single_peclr got=%b want=%b", {mm_pe_resetn, busy, fifo_count}, {1'b0, 1'b1, 3'd0}); else n_pass++;
    exp_job = exp_q.pop_front();
    n_checks++; if (mm_vec !== exp_job) $display("FAIL single_addr got=%h want=%h", mm_vec, exp_job); else n_pass++;
    @(negedge clk);
    n_checks++; if ({mm_pe_resetn, mm_start_reg} !== 2'b11) $display("FAIL single_start got=%b want=11", {mm_pe_resetn, mm_start_reg}); else n_pass++;
    @(negedge clk);
    n_checks++; if ({mm_start_reg, busy} !== 2'b01) $display("FAIL single_wait got=%b want=01", {mm_start_reg, busy}); else n_pass++;
    n = 1;
    while (!mm_clear_done_reg && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_checks++; if (n !== 21) $display("FAIL single_done_lat got=%0d want=21", n); else n_pass++;
    n_checks++; if ({mm_clear_done_reg, irq, jobs_done} !== {1'b1, 1'b1, 8'd1}) $display("FAIL single_clear got=%h want=%h", {mm_clear_done_reg, irq, jobs_done}, {1'b1, 1'b1, 8'd1}); else n_pass++;
    @(negedge clk);
    n_checks++; if ({mm_clear_done_reg, busy} !== 2'b00) $display("FAIL single_idle got=%b want=00", {mm_clear_done_reg, busy}); else n_pass++;
    ok = 1'b1;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n;
    logic [7:0] jd0;
    jd0 = jobs_done;
    done_delay = 3;
    push_job(10'h011, 10'h022, 10'h033, 8'd4, 8'd5, 8'd6);
    push_job(10'h044, 10'h055, 10'h066, 8'd7, 8'd8, 8'd9);
    for (int j = 0; j < 2; j++) begin
      if (j == 0) wait_pe_clr(ok);
      exp_job = exp_q.pop_front();
      n_checks++; if (!ok || mm_vec !== exp_job) $display("FAIL b2b_addr%0d got=%h want=%h", j, mm_vec, exp_job); else n_pass++;
      wait_clear(ok);
      n = 0;
      if (j == 0) begin
        while (mm_pe_resetn && n < 50) begin
          @(negedge clk);
          n++;
        end
        ok = !mm_pe_resetn;
        n_checks++; if (n !== 2) $display("FAIL b2b_gap got=%0d want=2", n); else n_pass++;
      end
    end
    n_checks++; if (jobs_done !== jd0 + 8'd2) $display("FAIL b2b_jobs got=%0d want=%0d", jobs_done, jd0 + 8'd2); else n_pass++;
  endtask

  task automatic test_fill();
    bit ok;
    logic [7:0] jd0;
    jd0 = jobs_done;
    done_delay = 20;
    push_job(10'h100, 10'h101, 10'h102, 8'd10, 8'd11, 8'd12);
    wait_pe_clr(ok);
    exp_job = exp_q.pop_front();
    n_checks++; if (!ok || mm_vec !== exp_job) $display("FAIL fill_addr0 got=%h want=%h", mm_vec, exp_job); else n_pass++;
    repeat (2) @(negedge clk);
    for (int i = 1; i <= 4; i++)
      push_job(AW'(i * 16), AW'(i * 16 + 1), AW'(i * 16 + 2), SW'(i), SW'(i + 1), SW'(i + 2));
    @(negedge clk);
    n_checks++; if ({fifo_count, job_ready, busy} !== {3'd4, 1'b0, 1'b1}) $display("FAIL fill_full got=%b want=%b", {fifo_count, job_ready, busy}, {3'd4, 1'b0, 1'b1}); else n_pass++;
    wait_clear(ok);
    for (int i = 1; i <= 4; i++) begin
      wait_pe_clr(ok);
      exp_job = exp_q.pop_front();
      n_checks++; if (!ok || mm_vec !== exp_job) $display("FAIL fill_addr%0d got=%h want=%h", i, mm_vec, exp_job); else n_pass++;
      wait_clear(ok);
    end
    n_checks++; if (jobs_done !== jd0 + 8'd5) $display("FAIL fill_jobs got=%0d want=%0d", jobs_done, jd0 + 8'd5); else n_pass++;
  endtask

  task automatic test_irq_clear();
    bit ok;
    done_delay = 4;
    @(negedge clk); irq_clear = 1'b1;
    @(negedge clk); irq_clear = 1'b0;
    n_checks++; if (irq !== 1'b0) $display("FAIL irq_pre_clear got=%b want=0", irq); else n_pass++;
    push_job(10'h3a0, 10'h3b0, 10'h3c0, 8'd2, 8'd3, 8'd4);
    wait_pe_clr(ok);
    exp_job = exp_q.pop_front();
    n_checks++; if (!ok || mm_vec !== exp_job) $display("FAIL irq_addr got=%h want=%h", mm_vec, exp_job); else n_pass++;
    wait_clear(ok);
    n_checks++; if (!ok || irq !== 1'b1) $display("FAIL irq_set got=%b want=1", irq); else n_pass++;
    irq_clear = 1'b1;
    @(negedge clk); irq_clear = 1'b0;
    n_checks++; if (irq !== 1'b1) $display("FAIL irq_set_wins got=%b want=1", irq); else n_pass++;
    @(negedge clk); irq_clear = 1'b1;
    @(negedge clk); irq_clear = 1'b0;
    n_checks++; if (irq !== 1'b0) $display("FAIL irq_standalone got=%b want=0", irq); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit pulse;
    done_delay = 30;
    push_job(10'h155, 10'h0aa, 10'h2cc, 8'd3, 8'd3, 8'd3);
    wait_pe_clr(ok);
    exp_job = exp_q.pop_front();
    n_checks++; if (!ok || mm_vec !== exp_job) $display("FAIL rmid_addr got=%h want=%h", mm_vec, exp_job); else n_pass++;
    push_job(10'h001, 10'h002, 10'h003, 8'd1, 8'd2, 8'd3);
    push_job(10'h004, 10'h005, 10'h006, 8'd4, 8'd5, 8'd6);
    @(negedge clk);
    n_checks++; if ({fifo_count, busy} !== {3'd2, 1'b1}) $display("FAIL rmid_queued got=%b want=%b", {fifo_count, busy}, {3'd2, 1'b1}); else n_pass++;
    #2 resetn = 1'b0;
    #1;
    exp_q.delete();
    n_checks++; if (ctl_vec !== 7'b1100000) $display("FAIL rmid_ctl got=%b want=%b", ctl_vec, 7'b1100000); else n_pass++;
    n_checks++; if ({fifo_count, jobs_done} !== 11'd0) $display("FAIL rmid_count got=%h want=0", {fifo_count, jobs_done}); else n_pass++;
    n_checks++; if (mm_vec !== '0) $display("FAIL rmid_addr_rst got=%h want=0", mm_vec); else n_pass++;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    pulse = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (!mm_pe_resetn || mm_start_reg || mm_clear_done_reg || busy) pulse = 1'b1;
    end
    n_checks++; if ({pulse, fifo_count} !== 4'd0) $display("FAIL rmid_quiet got=%b want=0000", {pulse, fifo_count}); else n_pass++;
  endtask

  task automatic test_wrap();
    bit ok;
    int bad = 0;
    test_reset();
    done_delay = 1;
    for (int i = 0; i < 257; i++) begin
      push_job(AW'(i), AW'(i * 3), AW'(1023 - i), SW'(i), SW'(i + 1), SW'(255 - i));
      wait_pe_clr(ok);
      exp_job = exp_q.pop_front();
      if (!ok || mm_vec !== exp_job) bad++;
      wait_clear(ok);
      if (!ok) bad++;
    end
    n_checks++; if (bad !== 0) $display("FAIL wrap_jobs got=%0d bad jobs want=0", bad); else n_pass++;
    n_checks++; if (jobs_done !== 8'd1) $display("FAIL wrap_count got=%0d want=1", jobs_done); else n_pass++;
  endtask

`ifdef MATMUL_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int n;
    logic [7:0] jd0;
    jd0 = jobs_done;
    done_en = 1'b0;
    @(negedge clk); irq_clear = 1'b1;
    @(negedge clk); irq_clear = 1'b0;
    push_job(10'h0f0, 10'h0f1, 10'h0f2, 8'd1, 8'd1, 8'd1);
    wait_pe_clr(ok);
    exp_job = exp_q.pop_front();
    n_checks++; if (!ok || mm_vec !== exp_job) $display("FAIL tmo_addr got=%h want=%h", mm_vec, exp_job); else n_pass++;
    @(negedge clk);
    n = 0;
    while (!mm_clear_done_reg && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_checks++; if (n !== TMO + 1) $display("FAIL tmo_latency got=%0d want=%0d", n, TMO + 1); else n_pass++;
    n_checks++; if ({err_timeout, irq, jobs_done} !== {1'b1, 1'b1, jd0}) $display("FAIL tmo_flags got=%h want=%h", {err_timeout, irq, jobs_done}, {1'b1, 1'b1, jd0}); else n_pass++;
    done_en = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fill();
    test_irq_clear();
    test_reset_mid();
    test_wrap();
`ifdef MATMUL_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
